// File: rtl/spi_cmd_slave_if.sv
// Command-bus interface between the SPI command slave and the register modules.
// Carries the SPI pins together with the parallel strobe/select/data bus.
interface spi_cmd_slave_if #(
    parameter int unsigned NUM_MODULES = 4
) ();
    logic                       i_spi_sck;
    logic                       i_spi_mosi;
    logic                       i_spi_cs_b;
    logic                       o_spi_miso;
    logic [4:0]                 o_ioc;
    logic [7:0]                 o_data_out;
    logic [8*NUM_MODULES-1:0]   i_data_in;
    logic [NUM_MODULES-1:0]     o_cs;
    logic                       o_fetch_cmd;
    logic                       o_load_cmd;
    logic                       o_busy;

    modport slave (
        input  i_spi_sck,
        input  i_spi_mosi,
        input  i_spi_cs_b,
        input  i_data_in,
        output o_spi_miso,
        output o_ioc,
        output o_data_out,
        output o_cs,
        output o_fetch_cmd,
        output o_load_cmd,
        output o_busy
    );

    modport master (
        output i_spi_sck,
        output i_spi_mosi,
        output i_spi_cs_b,
        output i_data_in,
        input  o_spi_miso,
        input  o_ioc,
        input  o_data_out,
        input  o_cs,
        input  o_fetch_cmd,
        input  o_load_cmd,
        input  o_busy
    );
endinterface

// File: rtl/spi_cmd_slave.sv
// SPI mode-0 slave turning 2-byte host frames (command + data) into one-cycle
// load/fetch strobes on the register command bus; reads are serialised on MISO.
module spi_cmd_slave #(
    parameter int unsigned NUM_MODULES = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic            i_sys_clk,
    input  logic            i_rst,
    spi_cmd_slave_if.slave  bus
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned IOC_W  = 5;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned CNT_W  = 5;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        FETCH,
        RLOAD,
        RDATA,
        WDATA,
        DONE
    } state_t;

    state_t                 state;

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] csb_sync;
    logic                   sck_prev;
    logic                   csb_prev;
    logic                   armed;

    logic                   sck_s;
    logic                   mosi_s;
    logic                   csb_s;
    logic                   sck_rise;
    logic                   sck_fall;
    logic                   cs_fall;
    logic                   cs_rise;

    logic [CNT_W-1:0]       bit_cnt;
    logic [DATA_W-2:0]      rx_shift;
    logic [DATA_W-1:0]      rx_byte;
    logic [DATA_W-1:0]      tx_shift;
    logic [IDX_W-1:0]       idx;
    logic                   sel_valid;
    logic [IDX_W-1:0]       cmd_idx_c;
    logic                   cmd_valid_c;
    logic [DATA_W-1:0]      rd_byte;

    logic                   miso_q;
    logic [IOC_W-1:0]       ioc_q;
    logic [DATA_W-1:0]      data_out_q;
    logic [NUM_MODULES-1:0] cs_q;
    logic                   fetch_q;
    logic                   load_q;
    logic                   busy_q;

    // Pin synchronisers. CS_B resets to "low" so a frame already in progress at
    // reset release never produces a falling edge; armed gates o_busy until a
    // genuine high has been seen on the pin.
    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            sck_sync  <= '0;
            mosi_sync <= '0;
            csb_sync  <= '0;
            sck_prev  <= 1'b0;
            csb_prev  <= 1'b0;
            armed     <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.i_spi_sck};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.i_spi_mosi};
            csb_sync  <= {csb_sync[SYNC_STAGES-2:0], bus.i_spi_cs_b};
            sck_prev  <= sck_s;
            csb_prev  <= csb_s;
            armed     <= armed | csb_s;
        end
    end

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign csb_s    = csb_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev;
    assign sck_fall = ~sck_s & sck_prev;
    assign cs_fall  = csb_prev & ~csb_s;
    assign cs_rise  = ~csb_prev & csb_s;

    assign rx_byte     = {rx_shift, mosi_s};
    assign cmd_idx_c   = rx_byte[6:5];
    assign cmd_valid_c = (32'(cmd_idx_c) < NUM_MODULES);

    function automatic logic [NUM_MODULES-1:0] decode(input logic [IDX_W-1:0] sel);
        logic [NUM_MODULES-1:0] oh;
        oh = '0;
        for (int unsigned k = 0; k < NUM_MODULES; k++) begin
            oh[k] = (sel == IDX_W'(k));
        end
        return oh;
    endfunction

    // Read-data mux; out-of-range selects never reach a bus slice.
    always_comb begin
        rd_byte = '0;
        for (int unsigned k = 0; k < NUM_MODULES; k++) begin
            if (idx == IDX_W'(k)) begin
                rd_byte = bus.i_data_in[k*DATA_W +: DATA_W];
            end
        end
    end

    // Frame sequencer. Strobes are registered on the edge that detects the 8th
    // (read) or 16th (write) SCK rise, so they are high during FETCH / first DONE cycle.
    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            rx_shift   <= '0;
            tx_shift   <= '0;
            idx        <= '0;
            sel_valid  <= 1'b0;
            miso_q     <= 1'b0;
            ioc_q      <= '0;
            data_out_q <= '0;
            cs_q       <= '0;
            fetch_q    <= 1'b0;
            load_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            fetch_q <= 1'b0;
            load_q  <= 1'b0;
            cs_q    <= '0;
            busy_q  <= armed & ~csb_s;

            if ((state != IDLE) && cs_rise) begin
                state   <= IDLE;
                bit_cnt <= '0;
                miso_q  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        miso_q <= 1'b0;
                        if (cs_fall) begin
                            bit_cnt <= '0;
                            state   <= CMD;
                        end
                    end

                    CMD: begin
                        miso_q <= 1'b0;
                        if (sck_rise) begin
                            rx_shift <= rx_byte[DATA_W-2:0];
                            bit_cnt  <= bit_cnt + CNT_W'(1);
                            if (bit_cnt == CNT_W'(7)) begin
                                ioc_q     <= rx_byte[IOC_W-1:0];
                                idx       <= cmd_idx_c;
                                sel_valid <= cmd_valid_c;
                                if (rx_byte[7]) begin
                                    state <= WDATA;
                                end else begin
                                    state   <= FETCH;
                                    fetch_q <= cmd_valid_c;
                                    cs_q    <= cmd_valid_c ? decode(cmd_idx_c) : '0;
                                end
                            end
                        end
                    end

                    FETCH: begin
                        state <= RLOAD;
                    end

                    // Module answers one cycle after the strobe; capture it here.
                    RLOAD: begin
                        tx_shift <= sel_valid ? rd_byte : '0;
                        state    <= RDATA;
                    end

                    RDATA: begin
                        if (sck_fall) begin
                            miso_q   <= tx_shift[DATA_W-1];
                            tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                        end
                        if (sck_rise) begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                            if (bit_cnt == CNT_W'(15)) begin
                                miso_q <= 1'b0;
                                state  <= DONE;
                            end
                        end
                    end

                    WDATA: begin
                        miso_q <= 1'b0;
                        if (sck_rise) begin
                            rx_shift <= rx_byte[DATA_W-2:0];
                            bit_cnt  <= bit_cnt + CNT_W'(1);
                            if (bit_cnt == CNT_W'(15)) begin
                                data_out_q <= rx_byte;
                                load_q     <= sel_valid;
                                cs_q       <= sel_valid ? decode(idx) : '0;
                                state      <= DONE;
                            end
                        end
                    end

                    DONE: begin
                        miso_q <= 1'b0;
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.o_spi_miso  = miso_q;
    assign bus.o_ioc       = ioc_q;
    assign bus.o_data_out  = data_out_q;
    assign bus.o_cs        = cs_q;
    assign bus.o_fetch_cmd = fetch_q;
    assign bus.o_load_cmd  = load_q;
    assign bus.o_busy      = busy_q;

endmodule

// File: tb/tb_spi_cmd_slave.sv
// Bench for spi_cmd_slave: a 4-module and a 2-module instance share the SPI pins;
// register modules are modelled as registered responders to the fetch strobe.
module tb_spi_cmd_slave;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sck = 1'b0;
    logic mosi = 1'b0;
    logic cs_b = 1'b1;

    always #5 clk = ~clk;

    spi_cmd_slave_if #(.NUM_MODULES(4)) bus4 ();
    spi_cmd_slave_if #(.NUM_MODULES(2)) bus2 ();

    assign bus4.i_spi_sck  = sck;
    assign bus4.i_spi_mosi = mosi;
    assign bus4.i_spi_cs_b = cs_b;
    assign bus2.i_spi_sck  = sck;
    assign bus2.i_spi_mosi = mosi;
    assign bus2.i_spi_cs_b = cs_b;

    spi_cmd_slave #(.NUM_MODULES(4), .SYNC_STAGES(2)) dut4 (
        .i_sys_clk (clk),
        .i_rst     (rst),
        .bus       (bus4.slave)
    );

    spi_cmd_slave #(.NUM_MODULES(2), .SYNC_STAGES(2)) dut2 (
        .i_sys_clk (clk),
        .i_rst     (rst),
        .bus       (bus2.slave)
    );

    logic [7:0] rd_val [4] = '{8'h5A, 8'hA5, 8'hC3, 8'h96};

    // Register modules: output byte updates one cycle after a fetch strobe.
    always @(posedge clk) begin
        if (rst) begin
            bus4.i_data_in <= '0;
            bus2.i_data_in <= '0;
        end else begin
            if (bus4.o_fetch_cmd)
                for (int k = 0; k < 4; k++)
                    if (bus4.o_cs[k]) bus4.i_data_in[8*k +: 8] <= rd_val[k];
            if (bus2.o_fetch_cmd)
                for (int k = 0; k < 2; k++)
                    if (bus2.o_cs[k]) bus2.i_data_in[8*k +: 8] <= rd_val[k];
        end
    end

    int load4_n = 0, fetch4_n = 0, load2_n = 0, fetch2_n = 0, viol_n = 0;
    logic [3:0] cap_cs4 = '0;
    logic [4:0] cap_ioc4 = '0;
    logic [7:0] cap_dout4 = '0;
    logic [1:0] cap_cs2 = '0;

    // Strobe monitor: counts strobe cycles, snapshots the bus, flags protocol violations.
    always @(posedge clk) begin
        if (bus4.o_load_cmd || bus4.o_fetch_cmd) begin
            cap_cs4  <= bus4.o_cs;
            cap_ioc4 <= bus4.o_ioc;
            if (bus4.o_load_cmd) cap_dout4 <= bus4.o_data_out;
        end
        if (bus4.o_load_cmd)  load4_n  <= load4_n + 1;
        if (bus4.o_fetch_cmd) fetch4_n <= fetch4_n + 1;
        if (bus2.o_load_cmd || bus2.o_fetch_cmd) cap_cs2 <= bus2.o_cs;
        if (bus2.o_load_cmd)  load2_n  <= load2_n + 1;
        if (bus2.o_fetch_cmd) fetch2_n <= fetch2_n + 1;
        if ((bus4.o_load_cmd && bus4.o_fetch_cmd) || (bus2.o_load_cmd && bus2.o_fetch_cmd))
            viol_n <= viol_n + 1;
        if ((!bus4.o_load_cmd && !bus4.o_fetch_cmd && |bus4.o_cs) ||
            (!bus2.o_load_cmd && !bus2.o_fetch_cmd && |bus2.o_cs))
            viol_n <= viol_n + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sends the top n bits of tx MSB first at sys_clk/8, sampling MISO just before each rise.
    task automatic spi_bits(input logic [7:0] tx, input int n,
                            output logic [7:0] rx4, output logic [7:0] rx2);
        rx4 = '0;
        rx2 = '0;
        for (int i = 0; i < n; i++) begin
            mosi = tx[7-i];
            wait_clk(4);
            rx4 = {rx4[6:0], bus4.o_spi_miso};
            rx2 = {rx2[6:0], bus2.o_spi_miso};
            sck = 1'b1;
            wait_clk(4);
            sck = 1'b0;
        end
    endtask

    task automatic do_frame(input logic [7:0] cmd, input logic [7:0] data,
                            output logic [7:0] rx4, output logic [7:0] rx2);
        logic [7:0] d4, d2;
        mosi = cmd[7];
        cs_b = 1'b0;
        wait_clk(4);
        spi_bits(cmd, 8, d4, d2);
        spi_bits(data, 8, rx4, rx2);
        wait_clk(4);
        cs_b = 1'b1;
        wait_clk(8);
    endtask

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] data;
        int         exp_load4;
        int         exp_fetch4;
        logic [3:0] exp_cs4;
        logic [4:0] exp_ioc4;
        logic [7:0] exp_dout4;
        logic [7:0] exp_rx4;
        int         exp_str2;
        logic [1:0] exp_cs2;
        logic [7:0] exp_rx2;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic [7:0] rx4, rx2, d4, d2;
        int l4, f4, l2, f2;

        vecs[0] = '{8'h85, 8'h3C, 1, 0, 4'b0001, 5'h05, 8'h3C, 8'h00, 1, 2'b01, 8'h00};
        vecs[1] = '{8'h22, 8'h00, 0, 1, 4'b0010, 5'h02, 8'h3C, 8'hA5, 1, 2'b10, 8'hA5};
        vecs[2] = '{8'h03, 8'h00, 0, 1, 4'b0001, 5'h03, 8'h3C, 8'h5A, 1, 2'b01, 8'h5A};
        vecs[3] = '{8'hFF, 8'h81, 1, 0, 4'b1000, 5'h1F, 8'h81, 8'h00, 0, 2'b00, 8'h00};
        vecs[4] = '{8'h5E, 8'h00, 0, 1, 4'b0100, 5'h1E, 8'h81, 8'hC3, 0, 2'b00, 8'h00};
        vecs[5] = '{8'hA0, 8'h00, 1, 0, 4'b0010, 5'h00, 8'h00, 8'h00, 1, 2'b10, 8'h00};
        vecs[6] = '{8'h43, 8'h00, 0, 1, 4'b0100, 5'h03, 8'h00, 8'hC3, 0, 2'b00, 8'h00};
        vecs[7] = '{8'h7F, 8'h00, 0, 1, 4'b1000, 5'h1F, 8'h00, 8'h96, 0, 2'b00, 8'h00};

        wait_clk(4);
        rst = 1'b0;
        wait_clk(4);
        check("reset_ioc",   32'(bus4.o_ioc), 32'h0);
        check("reset_dout",  32'(bus4.o_data_out), 32'h0);
        check("reset_cs",    32'(bus4.o_cs), 32'h0);
        check("reset_miso",  32'(bus4.o_spi_miso), 32'h0);
        check("reset_busy",  32'(bus4.o_busy), 32'h0);
        check("reset_strb",  32'({bus4.o_load_cmd, bus4.o_fetch_cmd}), 32'h0);

        for (int i = 0; i < 8; i++) begin
            l4 = load4_n; f4 = fetch4_n; l2 = load2_n; f2 = fetch2_n;
            do_frame(vecs[i].cmd, vecs[i].data, rx4, rx2);
            check($sformatf("v%0d_load4", i),  32'(load4_n - l4),  32'(vecs[i].exp_load4));
            check($sformatf("v%0d_fetch4", i), 32'(fetch4_n - f4), 32'(vecs[i].exp_fetch4));
            check($sformatf("v%0d_cs4", i),    32'(cap_cs4),       32'(vecs[i].exp_cs4));
            check($sformatf("v%0d_capioc4", i), 32'(cap_ioc4),     32'(vecs[i].exp_ioc4));
            check($sformatf("v%0d_ioc4", i),   32'(bus4.o_ioc),    32'(vecs[i].exp_ioc4));
            check($sformatf("v%0d_dout4", i),  32'(bus4.o_data_out), 32'(vecs[i].exp_dout4));
            if (vecs[i].exp_load4 != 0)
                check($sformatf("v%0d_capdout4", i), 32'(cap_dout4), 32'(vecs[i].exp_dout4));
            check($sformatf("v%0d_rx4", i),    32'(rx4),           32'(vecs[i].exp_rx4));
            check($sformatf("v%0d_str2", i),   32'((load2_n - l2) + (fetch2_n - f2)), 32'(vecs[i].exp_str2));
            if (vecs[i].exp_str2 != 0)
                check($sformatf("v%0d_cs2", i), 32'(cap_cs2), 32'(vecs[i].exp_cs2));
            check($sformatf("v%0d_rx2", i),    32'(rx2),           32'(vecs[i].exp_rx2));
        end

        // Abort after the 12th rise of a write frame.
        l4 = load4_n;
        mosi = 1'b1;
        cs_b = 1'b0;
        wait_clk(4);
        spi_bits(8'h81, 8, d4, d2);
        spi_bits(8'hFF, 4, d4, d2);
        check("abort_busy_mid", 32'(bus4.o_busy), 32'h1);
        wait_clk(4);
        cs_b = 1'b1;
        wait_clk(8);
        check("abort_noload", 32'(load4_n - l4), 32'h0);
        check("abort_busy",   32'(bus4.o_busy), 32'h0);
        check("abort_miso",   32'(bus4.o_spi_miso), 32'h0);
        l4 = load4_n;
        do_frame(8'h81, 8'h11, rx4, rx2);
        check("after_abort_load", 32'(load4_n - l4), 32'h1);
        check("after_abort_dout", 32'(cap_dout4), 32'h11);
        check("after_abort_cs",   32'(cap_cs4), 32'h1);
        check("after_abort_ioc",  32'(cap_ioc4), 32'h01);

        // 24 SCK cycles in one CS window.
        l4 = load4_n;
        mosi = 1'b1;
        cs_b = 1'b0;
        wait_clk(4);
        spi_bits(8'h85, 8, d4, d2);
        spi_bits(8'h3C, 8, d4, d2);
        spi_bits(8'hFF, 8, rx4, rx2);
        wait_clk(4);
        cs_b = 1'b1;
        wait_clk(8);
        check("extra_load", 32'(load4_n - l4), 32'h1);
        check("extra_dout", 32'(cap_dout4), 32'h3C);
        check("extra_miso", 32'(rx4), 32'h0);

        // Synchronous reset at the 5th rise of read frame 0x03.
        l4 = load4_n; f4 = fetch4_n;
        mosi = 1'b0;
        cs_b = 1'b0;
        wait_clk(4);
        spi_bits(8'h03, 4, d4, d2);
        mosi = 1'b0;
        wait_clk(4);
        sck = 1'b1;
        wait_clk(1);
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        wait_clk(1);
        check("rst_ioc",  32'(bus4.o_ioc), 32'h0);
        check("rst_dout", 32'(bus4.o_data_out), 32'h0);
        check("rst_cs",   32'(bus4.o_cs), 32'h0);
        check("rst_busy", 32'(bus4.o_busy), 32'h0);
        check("rst_miso", 32'(bus4.o_spi_miso), 32'h0);
        sck = 1'b0;
        spi_bits(8'h60, 3, d4, d2);
        spi_bits(8'h00, 8, rx4, rx2);
        wait_clk(4);
        cs_b = 1'b1;
        wait_clk(8);
        check("rst_nostrobe", 32'((load4_n - l4) + (fetch4_n - f4)), 32'h0);
        check("rst_busy_end", 32'(bus4.o_busy), 32'h0);
        f4 = fetch4_n;
        do_frame(8'h03, 8'h00, rx4, rx2);
        check("post_rst_fetch", 32'(fetch4_n - f4), 32'h1);
        check("post_rst_cs",    32'(cap_cs4), 32'h1);
        check("post_rst_ioc",   32'(bus4.o_ioc), 32'h03);
        check("post_rst_rx",    32'(rx4), 32'h5A);

        check("protocol_violations", 32'(viol_n), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_cmd_slave.md
Name: spi_cmd_slave

Overview:
SPI slave front end that converts host register transactions into the parallel command bus consumed by the I/O-control and sibling register modules. It receives a 2-byte frame: a command byte (R/W flag, module select, IOC) followed by a data byte. On writes it issues a one-cycle load strobe. On reads it issues a one-cycle fetch strobe and serialises the selected module's returned byte onto MISO. SPI pins are asynchronous to i_sys_clk and are oversampled.

Parameters:
NUM_MODULES, 4, number of register modules addressed; width of o_cs and of the i_data_in bus (8 bits per module).
SYNC_STAGES, 2, flip-flop depth of the SCK/MOSI/CS_B synchronisers (minimum 2).

Ports:
i_sys_clk  in  1  system clock; all logic on rising edge.
i_rst  in  1  synchronous, active-high reset.
i_spi_sck  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0); must be ≤ i_sys_clk/8.
i_spi_mosi  in  1  serial data in, MSB first.
i_spi_cs_b  in  1  chip select, active low.
o_spi_miso  out  1  serial data out, MSB first.
o_ioc  out  5  IOC field of the current command.
o_data_out  out  8  write data to modules.
i_data_in  in  8*NUM_MODULES  read data; module k occupies bits [8k+7:8k].
o_cs  out  NUM_MODULES  one-hot module select, asserted only with a strobe.
o_fetch_cmd  out  1  one-cycle read strobe.
o_load_cmd  out  1  one-cycle write strobe.
o_busy  out  1  high while CS_B is synchronised-low.

Behaviour:
- Reset values: o_spi_miso=0, o_ioc=0, o_data_out=0, o_cs=0, o_fetch_cmd=0, o_load_cmd=0, o_busy=0, state=IDLE, bit counter=0.
- Synchronisation: SCK, MOSI and CS_B each pass through SYNC_STAGES flip-flops. Rise/fall edges are detected on synchronised SCK by comparison with its previous value.
- Command byte layout: bit7 = W (1 = write, 0 = read); bits6:5 = module index; bits4:0 = IOC.
- A module index ≥ NUM_MODULES is an invalid select: no strobe is issued, MISO returns 0x00, and the frame is otherwise consumed normally.
- State machine:
  - IDLE: waits for synchronised CS_B to fall, then clears the bit counter and enters CMD.
  - CMD: on each SCK rise, shifts in MOSI. On the 8th rise, latches o_ioc and the module index. If W=1, goes to WDATA. If W=0, goes to FETCH.
  - FETCH: asserts o_fetch_cmd and o_cs[index] for exactly 1 cycle, then enters RLOAD.
  - RLOAD: one cycle later, captures the selected i_data_in byte into the TX shift register (module output is registered, so data is valid 1 cycle after the strobe). Enters RDATA.
  - RDATA: on each SCK fall, drives o_spi_miso from TX bit7 and shifts left. The first fall after the 8th rise presents read bit7. After 8 further rises, enters DONE.
  - WDATA: on each SCK rise, shifts in MOSI. After the 16th rise overall, drives o_data_out = received byte, asserts o_load_cmd and o_cs[index] for exactly 1 cycle, then enters DONE.
  - DONE: ignores further SCK edges; o_spi_miso=0. Returns to IDLE on CS_B rise.
- During CMD and WDATA, o_spi_miso=0.
- o_fetch_cmd and o_load_cmd are never high in the same cycle. Each is high for at most one cycle per frame.
- o_cs is 0 whenever neither strobe is high.
- CS_B rise in any state other than IDLE aborts the frame immediately (next cycle): state=IDLE, counter=0, o_spi_miso=0, and no pending strobe issues. A strobe already issued is not retracted.
- CS_B fall while in DONE waiting for the rise is impossible without an intervening rise. A glitch shorter than SYNC_STAGES cycles may be ignored.
- i_rst mid-frame: returns to reset values next cycle. The frame in progress is discarded until CS_B next falls after reset release.
- o_ioc and o_data_out hold their last values between frames.
- Strobe timing: write strobe occurs SYNC_STAGES+1 cycles after the 16th SCK rise at the pin; fetch strobe likewise after the 8th rise. With SCK ≤ sys_clk/8, the captured read data is in the TX register before the 8th falling edge is detected.

Test Plan:
- Write frame 0x85,0x3C (W=1, module 0, IOC 5), SCK = sys_clk/8 -> single o_load_cmd pulse with o_cs=0001, o_ioc=5'h05, o_data_out=0x3C; o_fetch_cmd stays 0.
- Read frame 0x22 (module 1, IOC 2), i_data_in[15:8]=0xA5 registered one cycle after the strobe -> single o_fetch_cmd pulse with o_cs=0010, o_ioc=5'h02; MISO bits during the data byte read 1,0,1,0,0,1,0,1.
- Abort: CS_B raised after the 12th SCK rise of write frame 0x81,0xFF -> no o_load_cmd, o_busy falls, state IDLE; a following full write 0x81,0x11 loads 0x11.
- Extra clocks: 24 SCK cycles within one CS_B window on a write frame -> exactly one o_load_cmd pulse; MISO=0 after byte 2.
- Synchronous reset asserted for 2 cycles at the 5th SCK rise of a read frame -> all outputs 0, no strobe; the next complete read frame 0x03 works normally.
- Invalid select with NUM_MODULES=2, read frame 0x43 (module 2) -> no strobe, o_cs=00, MISO returns 0x00.
